// File: rtl/alu_drv_pkg.sv
// Shared types and constants for the ALU load-sequence driver.
//   state_t : sequencer states, listed in the order the protocol walks them
//   FR_*    : bit positions of the ALU flags inside FR. The flags are passed
//             through unchanged.
//   DATA_W  : ALU data width
//   FR_W    : ALU flag width
package alu_drv_pkg;

  localparam int DATA_W = 32;
  localparam int FR_W   = 4;

  localparam int FR_ZF = 0;
  localparam int FR_CF = 1;
  localparam int FR_OF = 2;
  localparam int FR_SF = 3;

  typedef enum logic [3:0] {
    IDLE,
    RST_LO,
    RST_HI,
    SET_A,
    A_HI,
    A_LO,
    SET_B,
    B_HI,
    B_LO,
    SET_F,
    F_HI,
    F_LO,
    SETTLE,
    RESP
  } state_t;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times the length of each sequencer state.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load the counter with load_val (takes priority over counting)
//   load_val   : state length in cycles, must be >= 1
//   done       : terminal count; high in the last cycle of the timed interval
module phase_timer #(
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [TW-1:0] load_val,
  output logic          done
);

  logic [TW-1:0] count;

  // The count is loaded as load_val-1, so done rises after load_val-1 further
  // edges. The state that started the timer therefore lasts exactly load_val cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (start) begin
      count <= load_val - TW'(1);
    end else if (count != '0) begin
      count <= count - TW'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/alu_seq_driver.sv
// Hardware initiator for the ALU register-top load protocol. The driver
// accepts one {A, B, op} request and drives the ALU strobes in this order:
// an optional clear, then load A, load B and load op. It then captures F/FR
// and returns them on a valid/ready response channel.
//
// Every output comes straight from a flop. The alu_clk_* lines are used as
// clocks at the ALU, so they must be glitch-free.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake; req_ready is high only in IDLE
//   req_a, req_b, req_op request operands and opcode
//   rsp_valid/rsp_ready  response handshake
//   rsp_f, rsp_fr        captured ALU result and flags
//   alu_rst_n            ALU reset (low only in RST_LO and during our reset)
//   alu_clk_a/b/f        ALU load strobes
//   alu_in               ALU data input
//   alu_f, alu_fr        ALU result and flags
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a request, req_ready=1
// RST_LO | ALU clear pulse, alu_rst_n=0
// RST_HI | clear released
// SET_A  | alu_in <= A, set up before the strobe
// A_HI   | alu_clk_a high
// A_LO   | alu_clk_a low, alu_in held
// SET_B  | alu_in <= B
// B_HI   | alu_clk_b high
// B_LO   | alu_clk_b low, alu_in held
// SET_F  | alu_in <= zero-extended op
// F_HI   | alu_clk_f high
// F_LO   | alu_clk_f low, alu_in held
// SETTLE | waiting for F/FR to settle; captured on the last cycle
// RESP   | result held; rsp_valid until rsp_ready
module alu_seq_driver
  import alu_drv_pkg::*;
#(
  parameter int PHASE_CYC = 1,
  parameter int SETTLE_CYC = 1,
  parameter bit CLR_EACH = 1'b1,
  parameter int OP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [OP_W-1:0]   req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_f,
  output logic [FR_W-1:0]   rsp_fr,
  output logic              alu_rst_n,
  output logic              alu_clk_a,
  output logic              alu_clk_b,
  output logic              alu_clk_f,
  output logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] alu_f,
  input  logic [FR_W-1:0]   alu_fr
);

  localparam int TMR_W = 16;

  state_t              state, state_next;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [OP_W-1:0]     op_q;
  logic                tmr_start, tmr_done;
  logic [TMR_W-1:0]    tmr_load;
  logic                req_ready_d, rsp_valid_d, alu_rst_n_d;
  logic                clk_a_d, clk_b_d, clk_f_d, capture;
  logic [DATA_W-1:0]   alu_in_d;
  logic [FR_W-1:0]     fr_raw;

  phase_timer #(.TW(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (tmr_start),
    .load_val (tmr_load),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (req_valid && req_ready) state_next = CLR_EACH ? RST_LO : SET_A;
      RST_LO:  if (tmr_done) state_next = RST_HI;
      RST_HI:  if (tmr_done) state_next = SET_A;
      SET_A:   if (tmr_done) state_next = A_HI;
      A_HI:    if (tmr_done) state_next = A_LO;
      A_LO:    if (tmr_done) state_next = SET_B;
      SET_B:   if (tmr_done) state_next = B_HI;
      B_HI:    if (tmr_done) state_next = B_LO;
      B_LO:    if (tmr_done) state_next = SET_F;
      SET_F:   if (tmr_done) state_next = F_HI;
      F_HI:    if (tmr_done) state_next = F_LO;
      F_LO:    if (tmr_done) state_next = SETTLE;
      SETTLE:  if (tmr_done) state_next = RESP;
      RESP:    if (rsp_valid && rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Restart the timer on every state change. IDLE and RESP ignore it.
    tmr_start = (state_next != state);
    tmr_load  = (state_next == SETTLE) ? TMR_W'(SETTLE_CYC) : TMR_W'(PHASE_CYC);

    // Each registered output is computed from the next state, so it changes
    // on the same edge as the state itself.
    req_ready_d = (state_next == IDLE);
    alu_rst_n_d = (state_next != RST_LO);
    clk_a_d     = (state_next == A_HI);
    clk_b_d     = (state_next == B_HI);
    clk_f_d     = (state_next == F_HI);
    // The response is raised one cycle after capture and drops on the handshake edge.
    rsp_valid_d = (state == RESP) && (state_next == RESP);
    capture     = (state == SETTLE) && (state_next == RESP);

    alu_in_d = alu_in;
    if (state_next != state) begin
      case (state_next)
        // Going straight from IDLE skips the operand latch, so A is taken from the port.
        SET_A:   alu_in_d = (state == IDLE) ? req_a : a_q;
        SET_B:   alu_in_d = b_q;
        SET_F:   alu_in_d = DATA_W'(op_q);
        default: alu_in_d = alu_in;
      endcase
    end

    fr_raw        = '0;
    fr_raw[FR_ZF] = alu_fr[FR_ZF];
    fr_raw[FR_CF] = alu_fr[FR_CF];
    fr_raw[FR_OF] = alu_fr[FR_OF];
    fr_raw[FR_SF] = alu_fr[FR_SF];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      alu_rst_n <= 1'b0;
      alu_clk_a <= 1'b0;
      alu_clk_b <= 1'b0;
      alu_clk_f <= 1'b0;
      alu_in    <= '0;
    end else begin
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      alu_rst_n <= alu_rst_n_d;
      alu_clk_a <= clk_a_d;
      alu_clk_b <= clk_b_d;
      alu_clk_f <= clk_f_d;
      alu_in    <= alu_in_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else if (state == IDLE && req_valid && req_ready) begin
      a_q  <= req_a;
      b_q  <= req_b;
      op_q <= req_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_f  <= '0;
      rsp_fr <= '0;
    end else if (capture) begin
      rsp_f  <= alu_f;
      rsp_fr <= fr_raw;
    end
  end

endmodule

// File: tb/tb_alu_seq_driver.sv
module tb_alu_seq_driver;
  import alu_drv_pkg::*;

  localparam int N  = 2;
  localparam int P0 = 1, S0 = 1;
  localparam bit C0 = 1'b1;
  localparam int P1 = 3, S1 = 2;
  localparam bit C1 = 1'b0;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;

  logic        req_valid [N];
  wire         req_ready [N];
  logic [31:0] req_a     [N];
  logic [31:0] req_b     [N];
  logic [3:0]  req_op    [N];
  wire         rsp_valid [N];
  logic        rsp_ready [N];
  wire  [31:0] rsp_f     [N];
  wire  [3:0]  rsp_fr    [N];
  wire         alu_rst_n [N];
  wire         alu_clk_a [N];
  wire         alu_clk_b [N];
  wire         alu_clk_f [N];
  wire  [31:0] alu_in    [N];
  wire  [31:0] alu_f     [N];
  wire  [3:0]  alu_fr    [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq_driver #(.PHASE_CYC(P0), .SETTLE_CYC(S0), .CLR_EACH(C0), .OP_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_a(req_a[0]), .req_b(req_b[0]), .req_op(req_op[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_f(rsp_f[0]), .rsp_fr(rsp_fr[0]),
    .alu_rst_n(alu_rst_n[0]), .alu_clk_a(alu_clk_a[0]), .alu_clk_b(alu_clk_b[0]),
    .alu_clk_f(alu_clk_f[0]), .alu_in(alu_in[0]), .alu_f(alu_f[0]), .alu_fr(alu_fr[0])
  );

  alu_seq_driver #(.PHASE_CYC(P1), .SETTLE_CYC(S1), .CLR_EACH(C1), .OP_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_a(req_a[1]), .req_b(req_b[1]), .req_op(req_op[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_f(rsp_f[1]), .rsp_fr(rsp_fr[1]),
    .alu_rst_n(alu_rst_n[1]), .alu_clk_a(alu_clk_a[1]), .alu_clk_b(alu_clk_b[1]),
    .alu_clk_f(alu_clk_f[1]), .alu_in(alu_in[1]), .alu_f(alu_f[1]), .alu_fr(alu_fr[1])
  );

  // Behavioural ALU register top: the result is a function of the registered A, B and op.
  function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    logic [32:0] w;
    logic [31:0] r;
    logic        c, o;
    logic [3:0]  fr;
    c = 1'b0;
    o = 1'b0;
    case (op)
      4'd0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[31:0];
        c = w[32];
        o = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'd1: begin
        r = a - b;
        c = (a < b);
        o = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = a << b[4:0];
      4'd6:    r = a >> b[4:0];
      default: r = a;
    endcase
    fr = '0;
    fr[FR_ZF] = (r == 32'd0);
    fr[FR_CF] = c;
    fr[FR_OF] = o;
    fr[FR_SF] = r[31];
    return {fr, r};
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_alu
    logic [31:0] ra, rb;
    logic [3:0]  rop;
    wire  [35:0] res = alu_fn(ra, rb, rop);
    always @(posedge alu_clk_a[g] or negedge alu_rst_n[g])
      if (!alu_rst_n[g]) ra <= '0; else ra <= alu_in[g];
    always @(posedge alu_clk_b[g] or negedge alu_rst_n[g])
      if (!alu_rst_n[g]) rb <= '0; else rb <= alu_in[g];
    always @(posedge alu_clk_f[g] or negedge alu_rst_n[g])
      if (!alu_rst_n[g]) rop <= '0; else rop <= alu_in[g][3:0];
    assign alu_f[g]  = res[31:0];
    assign alu_fr[g] = res[35:32];
  end

  // Protocol monitor: edge counts, high/low durations, event times, violations.
  int          viol_excl [N], viol_stab [N];
  int          na [N], nb [N], nf [N], ha [N], hb [N], hf [N], nclr [N], lclr [N];
  int          tsa [N], tsb [N], tsf [N], tsc [N];
  logic        pa [N], pb [N], pf [N], prn [N];
  logic [31:0] pin [N];

  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      if ((int'(alu_clk_a[g]) + int'(alu_clk_b[g]) + int'(alu_clk_f[g])) > 1)
        viol_excl[g] <= viol_excl[g] + 1;
      if ((alu_clk_a[g] || alu_clk_b[g] || alu_clk_f[g]) && (alu_in[g] !== pin[g]))
        viol_stab[g] <= viol_stab[g] + 1;
      if (alu_clk_a[g] === 1'b1 && pa[g] === 1'b0) begin na[g] <= na[g] + 1; tsa[g] <= cyc; end
      if (alu_clk_b[g] === 1'b1 && pb[g] === 1'b0) begin nb[g] <= nb[g] + 1; tsb[g] <= cyc; end
      if (alu_clk_f[g] === 1'b1 && pf[g] === 1'b0) begin nf[g] <= nf[g] + 1; tsf[g] <= cyc; end
      if (alu_rst_n[g] === 1'b0 && prn[g] === 1'b1) begin nclr[g] <= nclr[g] + 1; tsc[g] <= cyc; end
      if (alu_clk_a[g] === 1'b1) ha[g] <= ha[g] + 1;
      if (alu_clk_b[g] === 1'b1) hb[g] <= hb[g] + 1;
      if (alu_clk_f[g] === 1'b1) hf[g] <= hf[g] + 1;
      if (alu_rst_n[g] === 1'b0) lclr[g] <= lclr[g] + 1;
      pa[g]  <= alu_clk_a[g];
      pb[g]  <= alu_clk_b[g];
      pf[g]  <= alu_clk_f[g];
      prn[g] <= alu_rst_n[g];
      pin[g] <= alu_in[g];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int p_of(input int k);   return (k == 0) ? P0 : P1; endfunction
  function automatic int s_of(input int k);   return (k == 0) ? S0 : S1; endfunction
  function automatic bit clr_of(input int k); return (k == 0) ? C0 : C1; endfunction

  int e_acc [N];
  int s_na [N], s_nb [N], s_nf [N], s_ha [N], s_hb [N], s_hf [N], s_nclr [N], s_lclr [N];

  task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, output int waited);
    req_a[k] = a; req_b[k] = b; req_op[k] = op; req_valid[k] = 1'b1;
    s_na[k] = na[k]; s_nb[k] = nb[k]; s_nf[k] = nf[k];
    s_ha[k] = ha[k]; s_hb[k] = hb[k]; s_hf[k] = hf[k];
    s_nclr[k] = nclr[k]; s_lclr[k] = lclr[k];
    waited = 0;
    while (req_ready[k] !== 1'b1 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (req_ready[k] !== 1'b1) begin
      check("accept_timeout", 64'd0, 64'd1);
      req_valid[k] = 1'b0;
      return;
    end
    e_acc[k] = cyc + 1;
    @(negedge clk);
    req_valid[k] = 1'b0;
    check("busy_not_ready", req_ready[k], 64'd0);
  endtask

  task automatic finish_txn(input int k, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input int bp, input bit chain,
                            input logic [31:0] a2, input logic [31:0] b2, input logic [3:0] op2);
    logic [35:0] exp;
    int n, p, lat_exp;
    bit clr;
    exp = alu_fn(a, b, op);
    p   = p_of(k);
    clr = clr_of(k);
    lat_exp = (clr ? 11 : 9) * p + s_of(k) + 1;
    n = 0;
    while (rsp_valid[k] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (rsp_valid[k] !== 1'b1) begin
      check("rsp_timeout", 64'd0, 64'd1);
      return;
    end
    check("latency", cyc - e_acc[k], lat_exp);
    check("rsp_f", rsp_f[k], exp[31:0]);
    check("rsp_fr", rsp_fr[k], exp[35:32]);
    if (chain) begin
      req_a[k] = a2; req_b[k] = b2; req_op[k] = op2; req_valid[k] = 1'b1;
    end
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_valid", rsp_valid[k], 64'd1);
      check("bp_f", rsp_f[k], exp[31:0]);
      check("bp_fr", rsp_fr[k], exp[35:32]);
      check("bp_req_ready", req_ready[k], 64'd0);
    end
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    check("rsp_drop", rsp_valid[k], 64'd0);
    check("idle_ready", req_ready[k], 64'd1);
    check("f_hold", rsp_f[k], exp[31:0]);
    check("clr_pulses", nclr[k] - s_nclr[k], clr ? 1 : 0);
    check("clr_len", lclr[k] - s_lclr[k], clr ? p : 0);
    check("edges_a", na[k] - s_na[k], 64'd1);
    check("edges_b", nb[k] - s_nb[k], 64'd1);
    check("edges_f", nf[k] - s_nf[k], 64'd1);
    check("hi_a", ha[k] - s_ha[k], p);
    check("hi_b", hb[k] - s_hb[k], p);
    check("hi_f", hf[k] - s_hf[k], p);
    check("order_ab", tsa[k] < tsb[k], 64'd1);
    check("order_bf", tsb[k] < tsf[k], 64'd1);
    if (clr) check("order_clr_a", tsc[k] < tsa[k], 64'd1);
    check("strobe_excl", viol_excl[k], 64'd0);
    check("in_stable", viol_stab[k], 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n, k, bp;
    logic [31:0] a, b;
    logic [3:0]  op;

    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b0; rsp_ready[i] = 1'b0;
      req_a[i] = '0; req_b[i] = '0; req_op[i] = '0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #20;
    for (int i = 0; i < N; i++) begin
      check("rst_alu_rst_n", alu_rst_n[i], 64'd0);
      check("rst_strobes", {alu_clk_a[i], alu_clk_b[i], alu_clk_f[i]}, 64'd0);
      check("rst_alu_in", alu_in[i], 64'd0);
      check("rst_req_ready", req_ready[i], 64'd0);
      check("rst_rsp_valid", rsp_valid[i], 64'd0);
      check("rst_rsp", {rsp_fr[i], rsp_f[i]}, 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check("rel_alu_rst_n", alu_rst_n[i], 64'd1);
      check("rel_req_ready", req_ready[i], 64'd1);
    end

    // Default parameters, 1 + 2 with ADD.
    issue(0, 32'd1, 32'd2, 4'd0, w);
    finish_txn(0, 32'd1, 32'd2, 4'd0, 0, 1'b0, '0, '0, '0);
    check("add_1_2", rsp_f[0], 64'd3);

    // Overflow: the result wraps to zero, which sets ZF and CF.
    issue(0, 32'hFFFF_FFFF, 32'd1, 4'd0, w);
    finish_txn(0, 32'hFFFF_FFFF, 32'd1, 4'd0, 0, 1'b0, '0, '0, '0);
    check("ovf_f", rsp_f[0], 64'd0);
    check("ovf_fr", rsp_fr[0], 64'h3);

    // PHASE_CYC=3, SETTLE_CYC=2, no clear.
    issue(1, 32'd5, 32'd9, 4'd0, w);
    finish_txn(1, 32'd5, 32'd9, 4'd0, 0, 1'b0, '0, '0, '0);
    check("p3_sum", rsp_f[1], 64'd14);

    // 20 cycles of backpressure while the next request is held valid.
    issue(0, 32'd7, 32'd8, 4'd1, w);
    finish_txn(0, 32'd7, 32'd8, 4'd1, 20, 1'b1, 32'd10, 32'd20, 4'd2);
    issue(0, 32'd10, 32'd20, 4'd2, w);
    check("b2b_wait", w, 64'd0);
    finish_txn(0, 32'd10, 32'd20, 4'd2, 0, 1'b0, '0, '0, '0);

    // Assert reset while clk_B is high.
    issue(0, 32'd3, 32'd4, 4'd0, w);
    n = 0;
    while (alu_clk_b[0] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_b_hi", alu_clk_b[0], 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_strobes", {alu_clk_a[0], alu_clk_b[0], alu_clk_f[0]}, 64'd0);
    check("mid_rst_alu_rst_n", alu_rst_n[0], 64'd0);
    check("mid_rst_rsp_valid", rsp_valid[0], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", req_ready[0], 64'd1);
    check("post_rst_rsp_valid", rsp_valid[0], 64'd0);
    check("post_rst_alu_rst_n", alu_rst_n[0], 64'd1);
    check("post_rst_strobes", {alu_clk_a[0], alu_clk_b[0], alu_clk_f[0]}, 64'd0);

    // Random traffic on both instances with random response backpressure.
    for (int i = 0; i < 200; i++) begin
      k  = int'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom;
      op = 4'($urandom_range(0, 15));
      bp = int'($urandom_range(0, 3));
      issue(k, a, b, op, w);
      finish_txn(k, a, b, op, bp, 1'b0, '0, '0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/alu_seq_driver.md
# alu_seq_driver

Hardware initiator for the lab-3 ALU register-top load protocol. It accepts one {A, B, op} request over a valid/ready handshake and generates the strobe sequence on the ALU top's four protocol inputs, in this order: optional clear, load A, load B, load op. It then captures the ALU result F and flags FR and returns them over a valid/ready response channel. It sits between a request source (CPU datapath stub or test harness) and the ALU top, replacing hand-driven strobes.

## Interface
- PHASE_CYC, 1: clock cycles per protocol phase, ≥1.
- SETTLE_CYC, 1: cycles between the op strobe falling and result capture, ≥1.
- CLR_EACH, 1: 1 issues an ALU clear pulse before every transaction; 0 skips it.
- OP_W, 4: opcode width, ≤32.
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- req_op  in  OP_W  ALU opcode.
- rsp_valid  out  1  result held.
- rsp_ready  in  1  consumer accepts.
- rsp_f  out  32  captured F.
- rsp_fr  out  4  captured FR.
- alu_rst_n  out  1  to ALU rst_n.
- alu_clk_a  out  1  to ALU clk_A.
- alu_clk_b  out  1  to ALU clk_B.
- alu_clk_f  out  1  to ALU clk_F.
- alu_in  out  32  to ALU in.
- alu_f  in  32  from ALU F.
- alu_fr  in  4  from ALU FR.

## Operation
- States: IDLE, RST_LO, RST_HI, SET_A, A_HI, A_LO, SET_B, B_HI, B_LO, SET_F, F_HI, F_LO, SETTLE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch a/b/op; go to RST_LO if CLR_EACH, otherwise SET_A.
- Each phase state lasts exactly PHASE_CYC cycles, then advances in list order. SETTLE lasts SETTLE_CYC cycles.
- RST_LO: alu_rst_n=0. In all other states alu_rst_n=1.
- alu_in:
  - Loaded with A on entry to SET_A, B on entry to SET_B, and {zeros, op} on entry to SET_F.
  - Otherwise holds its value, so it is stable across each HI and LO strobe phase.
- Strobes:
  - alu_clk_a=1 only in A_HI; alu_clk_b=1 only in B_HI; alu_clk_f=1 only in F_HI.
  - At most one strobe is high at any time.
- At the last SETTLE edge, sample alu_f/alu_fr into rsp_f/rsp_fr and enter RESP.
- RESP:
  - rsp_valid=1; rsp_f/rsp_fr are stable.
  - On rsp_ready, go to IDLE and clear rsp_valid. rsp_f/rsp_fr keep their value.
- Requests arriving in any non-IDLE state are not accepted (req_ready=0). There is no queueing.
- alu_in is not cleared on return to IDLE.

## Timing
- Every output is a flop; no combinational path from input to output. This matters because the alu_clk_* outputs are used as clocks and must be glitch-free.
- Reset values (asynchronous, while rst_n=0):
  - alu_rst_n=0, which holds the ALU in reset.
  - alu_clk_a=alu_clk_b=alu_clk_f=0, alu_in=0.
  - req_ready=0, rsp_valid=0, rsp_f=0, rsp_fr=0.
  - State IDLE.
- After reset release: alu_rst_n=1 and req_ready=1 from the first edge.
- Latency from the acceptance edge to rsp_valid=1:
  - CLR_EACH=1: 11·PHASE_CYC+SETTLE_CYC+1 cycles (13 with defaults).
  - CLR_EACH=0: 9·PHASE_CYC+SETTLE_CYC+1 cycles.
- Back-to-back throughput: the earliest next acceptance is the cycle after the rsp handshake.
- Reset asserted mid-transaction:
  - Strobes drop to 0 immediately; a falling strobe is not an ALU edge, so no spurious load occurs.
  - The response is discarded; nothing is replayed.

## Structure
- Package alu_drv_pkg holds:
  - the state enum;
  - FR bit indices (ZF=0, CF=1, OF=2, SF=3; passed through raw);
  - DATA_W=32 and FR_W=4.
- Sub-module phase_timer: loadable down-counter (load value, start, done pulse) shared by the phase and SETTLE waits.
- The FSM and the capture registers are in alu_seq_driver.

## Test plan
- Defaults, ALU top attached:
  - Stimulus: req a=1, b=2, op=0 (ADD).
  - Required: rsp_f=3; rsp_valid rises exactly 13 cycles after acceptance; one clear pulse and exactly one rising edge on each of clk_A, clk_B, clk_F, in that order.
- Overflow:
  - Stimulus: a=0xFFFF_FFFF, b=1, op=0.
  - Required: rsp_f=0; rsp_fr equals the ALU's FR with ZF and CF set.
- PHASE_CYC=3, SETTLE_CYC=2, CLR_EACH=0:
  - Stimulus: a=5, b=9.
  - Required: no alu_rst_n low pulse; each strobe is high exactly 3 cycles; latency is 30 cycles.
- Response backpressure:
  - Stimulus: rsp_ready held low 20 cycles.
  - Required: rsp_valid, rsp_f and rsp_fr stable throughout; req_ready stays 0; a request held valid is accepted the cycle after the rsp handshake.
- Reset mid-op:
  - Stimulus: rst_n asserted during B_HI.
  - Required: all strobes 0 and alu_rst_n 0 immediately; after release, IDLE with req_ready=1 and rsp_valid=0.
- Strobe exclusivity:
  - Stimulus: 200 random requests with random backpressure.
  - Required: at most one of clk_A/B/F high per cycle; alu_in never changes while any strobe is high.
